// File: rtl/ls_mem_access_pkg.sv
// Shared types and constants for the ls_mem_access load/store stage.
// Imported by the interface-level logic, the lane aligner and the top module.
package ls_pkg;

    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2,
        LS_RSVD = 2'd3
    } ls_size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        ERR
    } ls_state_e;

    localparam int unsigned LS_TIMEOUT_DEFAULT = 16;

    // Reserved size or a halfword/word not aligned to its own width.
    function automatic logic ls_bad_access(input ls_size_e size, input logic [1:0] addr_lo);
        case (size)
            LS_BYTE: return 1'b0;
            LS_HALF: return addr_lo[0];
            LS_WORD: return (addr_lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ls_mem_access_if.sv
// Word-addressed memory port with req/ack handshake used by ls_mem_access.
// master = access stage, slave = memory.
interface ls_mem_access_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/ls_mem_access_lane_align.sv
// Combinational lane steering: byte enables, store-data replication and
// right-justified, zero-filled load extraction (little-endian).
module ls_lane_align
    import ls_pkg::*;
(
    input  ls_size_e    size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_aligned
);

    always_comb begin
        be            = '0;
        wdata_lanes   = '0;
        rdata_aligned = '0;
        case (size)
            LS_BYTE: begin
                be            = 4'b0001 << addr_lo;
                wdata_lanes   = {4{wdata[7:0]}};
                rdata_aligned = {24'b0, rdata[{addr_lo, 3'b000} +: 8]};
            end
            LS_HALF: begin
                be            = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lanes   = {2{wdata[15:0]}};
                rdata_aligned = {16'b0, rdata[{addr_lo[1], 4'b0000} +: 16]};
            end
            LS_WORD: begin
                be            = 4'b1111;
                wdata_lanes   = wdata;
                rdata_aligned = rdata;
            end
            default: begin
                be            = '0;
                wdata_lanes   = '0;
                rdata_aligned = '0;
            end
        endcase
    end

endmodule

// File: rtl/ls_mem_access.sv
// Load/store memory-access stage: latches one request, runs the req/ack handshake
// and lane-aligns data. Define LS_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES.
module ls_mem_access
    import ls_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LS_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_load,
    input  logic [1:0]         size,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [31:0]        load_data,
    ls_mem_access_if.master    mem
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("ls_mem_access: TIMEOUT_CYCLES must be at least 1");
    end

    ls_state_e   state_q, state_d;
    logic        is_load_q, is_load_d;
    ls_size_e    size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mem_req_q, mem_req_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        timeout;

    ls_lane_align u_lane_align (
        .size          (size_q),
        .addr_lo       (addr_q[1:0]),
        .wdata         (wdata_q),
        .rdata         (mem.mem_rdata),
        .be            (lane_be),
        .wdata_lanes   (lane_wdata),
        .rdata_aligned (lane_rdata)
    );

`ifdef LS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts un-acked ACCESS cycles; any other state (or an ack) restarts it at zero.
    always_comb begin
        cnt_d = '0;
        if (state_q == ACCESS && !mem.mem_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_load_d = is_load;
                    size_d    = ls_size_e'(size);
                    addr_d    = addr;
                    wdata_d   = wdata;
                    state_d   = ls_bad_access(ls_size_e'(size), addr[1:0]) ? ERR : ACCESS;
                end
            end
            ACCESS: begin
                // An ack on the same edge the count expires takes priority.
                if (mem.mem_ack) begin
                    if (is_load_q) begin
                        load_data_d = lane_rdata;
                    end
                    state_d = RESP;
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d    = (state_d != IDLE);
        done_d    = (state_d == RESP) || (state_d == ERR);
        err_d     = (state_d == ERR);
        mem_req_d = (state_d == ACCESS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            is_load_q   <= 1'b0;
            size_q      <= LS_BYTE;
            addr_q      <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_load_q   <= is_load_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign load_data = load_data_q;

    // Bus fields are forced to zero outside a request so the port idles cleanly.
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_req_q & ~is_load_q;
    assign mem.mem_addr  = mem_req_q ? {addr_q[31:2], 2'b00} : '0;
    assign mem.mem_be    = mem_req_q ? lane_be : '0;
    assign mem.mem_wdata = mem_req_q ? lane_wdata : '0;

endmodule

// File: tb/tb_ls_mem_access.sv
// Testbench for ls_mem_access: directed vector table, hand sequences for
// reset/ignored-input/timeout corners, and randomized accesses against a byte-level memory model.
module tb_ls_mem_access;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam int unsigned NV         = 14;

    typedef struct {
        logic        ld;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int unsigned dly;
        logic        e_err;
        int unsigned e_lat;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_ld;
    } vec_t;

    typedef struct {
        logic        err;
        int unsigned lat;
        int unsigned req_cycles;
        logic [3:0]  be;
        logic        we;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        unstable;
        logic        done_after;
        logic        timed_out;
    } obs_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_load;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] load_data;

    int n_cmp;
    int n_bad;

    logic [31:0] dev_mem [16];
    logic [7:0]  ref_mem [64];
    logic [31:0] ld_track;

    ls_mem_access_if mif ();

    ls_mem_access #(
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_load   (is_load),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .load_data (load_data),
        .mem       (mif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one access and plays the memory: ack in the (dly+1)-th request cycle.
    // Returns with the DUT in the cycle after done.
    task automatic do_access(input logic ld, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int unsigned dly, input bit use_dev, output obs_t o);
        int unsigned reqc;
        bit          fin;
        o = '{default: '0};
        is_load = ld;
        size    = sz;
        addr    = a;
        wdata   = wd;
        start   = 1'b1;
        step();
        start   = 1'b0;
        is_load = 1'($urandom);
        size    = 2'($urandom);
        addr    = $urandom;
        wdata   = $urandom;
        reqc    = 0;
        fin     = 1'b0;
        for (int unsigned c = 1; c <= 100 && !fin; c++) begin
            mif.mem_ack   = 1'b0;
            mif.mem_rdata = $urandom;
            if (done) begin
                o.err = err;
                o.lat = c;
                fin   = 1'b1;
            end else begin
                if (mif.mem_req) begin
                    if (reqc == 0) begin
                        o.be     = mif.mem_be;
                        o.we     = mif.mem_we;
                        o.maddr  = mif.mem_addr;
                        o.mwdata = mif.mem_wdata;
                    end else if (o.be !== mif.mem_be || o.we !== mif.mem_we ||
                                 o.maddr !== mif.mem_addr || o.mwdata !== mif.mem_wdata) begin
                        o.unstable = 1'b1;
                    end
                    if (reqc == dly) begin
                        mif.mem_ack   = 1'b1;
                        mif.mem_rdata = use_dev ? dev_mem[mif.mem_addr[5:2]] : rd;
                        if (use_dev && mif.mem_we) begin
                            for (int i = 0; i < 4; i++) begin
                                if (mif.mem_be[i]) dev_mem[mif.mem_addr[5:2]][8*i +: 8] = mif.mem_wdata[8*i +: 8];
                            end
                        end
                    end
                    reqc++;
                end
                step();
            end
        end
        mif.mem_ack  = 1'b0;
        o.req_cycles = reqc;
        o.timed_out  = !fin;
        step();
        o.done_after = done;
    endtask

    vec_t        vt [NV];
    obs_t        o;
    logic        rl;
    logic [1:0]  rs;
    logic [31:0] ra;
    logic [31:0] rw;
    logic [31:0] val;
    int unsigned rdly;
    int unsigned nb;
    logic        e_err;

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //          ld  sz    addr          wdata         rdata        dly err lat be       addr          mem_wdata     load_data
        vt[0]  = '{1'b1, 2'd2, 32'h0000_0100, 32'h0,         32'hDEADBEEF, 2, 1'b0, 4, 4'b1111, 32'h0000_0100, 32'h0,         32'hDEADBEEF};
        vt[1]  = '{1'b1, 2'd0, 32'h0000_1003, 32'h0,         32'hAABBCCDD, 0, 1'b0, 2, 4'b1000, 32'h0000_1000, 32'h0,         32'h0000_00AA};
        vt[2]  = '{1'b0, 2'd1, 32'h0000_2002, 32'h0000_1234, 32'h0,        1, 1'b0, 3, 4'b1100, 32'h0000_2000, 32'h1234_1234, 32'h0000_00AA};
        vt[3]  = '{1'b1, 2'd2, 32'h0000_3001, 32'h0,         32'h0,        0, 1'b1, 1, 4'b0000, 32'h0,         32'h0,         32'h0000_00AA};
        vt[4]  = '{1'b1, 2'd1, 32'h0000_0012, 32'h0,         32'h11223344, 0, 1'b0, 2, 4'b1100, 32'h0000_0010, 32'h0,         32'h0000_1122};
        vt[5]  = '{1'b0, 2'd0, 32'h0000_0041, 32'hFFFFFF5A,  32'h0,        3, 1'b0, 5, 4'b0010, 32'h0000_0040, 32'h5A5A_5A5A, 32'h0000_1122};
        vt[6]  = '{1'b1, 2'd3, 32'h0000_0000, 32'h0,         32'h0,        0, 1'b1, 1, 4'b0000, 32'h0,         32'h0,         32'h0000_1122};
        vt[7]  = '{1'b1, 2'd1, 32'h0000_0005, 32'h0,         32'h0,        0, 1'b1, 1, 4'b0000, 32'h0,         32'h0,         32'h0000_1122};
        vt[8]  = '{1'b1, 2'd0, 32'h0000_0021, 32'h0,         32'h11223344, 0, 1'b0, 2, 4'b0010, 32'h0000_0020, 32'h0,         32'h0000_0033};
        vt[9]  = '{1'b1, 2'd1, 32'h0000_0020, 32'h0,         32'h8765CAFE, 1, 1'b0, 3, 4'b0011, 32'h0000_0020, 32'h0,         32'h0000_CAFE};
        vt[10] = '{1'b0, 2'd2, 32'h0000_0030, 32'h0BADF00D,  32'h0,        0, 1'b0, 2, 4'b1111, 32'h0000_0030, 32'h0BAD_F00D, 32'h0000_CAFE};
        vt[11] = '{1'b0, 2'd2, 32'h0000_0032, 32'h0BADF00D,  32'h0,        0, 1'b1, 1, 4'b0000, 32'h0,         32'h0,         32'h0000_CAFE};
        vt[12] = '{1'b1, 2'd0, 32'h0000_0102, 32'h0,         32'hAABBCCDD, 0, 1'b0, 2, 4'b0100, 32'h0000_0100, 32'h0,         32'h0000_00BB};
        vt[13] = '{1'b0, 2'd0, 32'h0000_0200, 32'h0000_00C3, 32'h0,        0, 1'b0, 2, 4'b0001, 32'h0000_0200, 32'hC3C3_C3C3, 32'h0000_00BB};

        reset         = 1'b1;
        start         = 1'b0;
        is_load       = 1'b0;
        size          = 2'd0;
        addr          = '0;
        wdata         = '0;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        step();
        step();
        chk("rst_busy",      busy,          0);
        chk("rst_done",      done,          0);
        chk("rst_err",       err,           0);
        chk("rst_load_data", load_data,     0);
        chk("rst_mem_req",   mif.mem_req,   0);
        chk("rst_mem_we",    mif.mem_we,    0);
        chk("rst_mem_addr",  mif.mem_addr,  0);
        chk("rst_mem_be",    mif.mem_be,    0);
        chk("rst_mem_wdata", mif.mem_wdata, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            do_access(vt[i].ld, vt[i].sz, vt[i].a, vt[i].wd, vt[i].rd, vt[i].dly, 1'b0, o);
            chk($sformatf("v%0d_bound", i), o.timed_out, 0);
            chk($sformatf("v%0d_err", i), o.err, vt[i].e_err);
            chk($sformatf("v%0d_latency", i), o.lat, vt[i].e_lat);
            chk($sformatf("v%0d_done_pulse", i), o.done_after, 0);
            if (vt[i].e_err) begin
                chk($sformatf("v%0d_no_req", i), o.req_cycles, 0);
            end else begin
                chk($sformatf("v%0d_be", i), o.be, vt[i].e_be);
                chk($sformatf("v%0d_we", i), o.we, !vt[i].ld);
                chk($sformatf("v%0d_addr", i), o.maddr, vt[i].e_addr);
                chk($sformatf("v%0d_stable", i), o.unstable, 0);
                if (!vt[i].ld) chk($sformatf("v%0d_wdata", i), o.mwdata, vt[i].e_wdata);
            end
            chk($sformatf("v%0d_load_data", i), load_data, vt[i].e_ld);
        end
        ld_track = 32'h0000_00BB;

        // Start presented while ERR is pulsing done must be ignored.
        is_load = 1'b1; size = 2'd2; addr = 32'h0000_3001; start = 1'b1;
        step();
        chk("errseq_done",    done,        1);
        chk("errseq_err",     err,         1);
        chk("errseq_mem_req", mif.mem_req, 0);
        addr = 32'h0000_0200;
        step();
        start = 1'b0;
        chk("errseq_ignored_busy", busy,        0);
        chk("errseq_ignored_req",  mif.mem_req, 0);
        chk("errseq_done_clear",   done,        0);

        // Ack while idle must not touch load_data.
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1234_5678;
        step(); step(); step();
        mif.mem_ack = 1'b0;
        chk("idle_ack_load_data", load_data, ld_track);
        chk("idle_ack_busy",      busy,      0);

        // Reset in the third ACCESS cycle abandons the transaction.
        is_load = 1'b1; size = 2'd2; addr = 32'h0000_0400; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("rstmid_req_before", mif.mem_req, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstmid_req",       mif.mem_req, 0);
        chk("rstmid_load_data", load_data,   0);
        chk("rstmid_busy",      busy,        0);
        chk("rstmid_done",      done,        0);
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFF_FFFF;
        step(); step();
        mif.mem_ack = 1'b0;
        chk("rstmid_late_ack_ld", load_data, 0);
        chk("rstmid_late_busy",   busy,      0);
        do_access(1'b1, 2'd0, 32'h0000_0502, 32'h0, 32'h0099_0000, 0, 1'b0, o);
        chk("rstmid_next_bound",   o.timed_out, 0);
        chk("rstmid_next_err",     o.err,       0);
        chk("rstmid_next_latency", o.lat,       2);
        chk("rstmid_next_be",      o.be,        4'b0100);
        chk("rstmid_next_ld",      load_data,   32'h0000_0099);
        ld_track = 32'h0000_0099;

`ifdef LS_TIMEOUT_EN
        do_access(1'b1, 2'd2, 32'h0000_0600, 32'h0, 32'h5555_5555, 1000, 1'b0, o);
        chk("tmo_bound",      o.timed_out,  0);
        chk("tmo_req_cycles", o.req_cycles, TB_TIMEOUT);
        chk("tmo_err",        o.err,        1);
        chk("tmo_latency",    o.lat,        TB_TIMEOUT + 1);
        chk("tmo_load_data",  load_data,    ld_track);
        chk("tmo_done_pulse", o.done_after, 0);
        do_access(1'b1, 2'd2, 32'h0000_0604, 32'h0, 32'h7777_7777, TB_TIMEOUT - 1, 1'b0, o);
        chk("tmo_ackwins_bound",   o.timed_out, 0);
        chk("tmo_ackwins_err",     o.err,       0);
        chk("tmo_ackwins_latency", o.lat,       TB_TIMEOUT + 1);
        chk("tmo_ackwins_ld",      load_data,   32'h7777_7777);
        ld_track = 32'h7777_7777;
`else
        do_access(1'b1, 2'd2, 32'h0000_0600, 32'h0, 32'h5555_5555, 20, 1'b0, o);
        chk("longwait_bound",      o.timed_out,  0);
        chk("longwait_req_cycles", o.req_cycles, 21);
        chk("longwait_err",        o.err,        0);
        chk("longwait_latency",    o.lat,        22);
        chk("longwait_ld",         load_data,    32'h5555_5555);
        ld_track = 32'h5555_5555;
`endif

        // Randomized accesses: the device holds words, the reference holds bytes.
        for (int w = 0; w < 16; w++) begin
            dev_mem[w] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = dev_mem[w][8*b +: 8];
        end
        for (int n = 0; n < 300; n++) begin
            rl   = 1'($urandom_range(0, 1));
            rs   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ra   = $urandom_range(0, 63);
            rw   = $urandom;
            rdly = $urandom_range(0, 3);
            e_err = (rs == 2'd3) || (rs == 2'd1 && ra % 2 != 0) || (rs == 2'd2 && ra % 4 != 0);
            nb    = 1 << rs;
            if (!e_err) begin
                if (rl) begin
                    val = '0;
                    for (int unsigned i = 0; i < nb; i++) val = val | (32'(ref_mem[ra + i]) << (8 * i));
                    ld_track = val;
                end else begin
                    for (int unsigned i = 0; i < nb; i++) ref_mem[ra + i] = rw[8*i +: 8];
                end
            end
            do_access(rl, rs, ra, rw, 32'h0, rdly, 1'b1, o);
            chk($sformatf("rnd%0d_bound", n), o.timed_out, 0);
            chk($sformatf("rnd%0d_err", n), o.err, e_err);
            chk($sformatf("rnd%0d_latency", n), o.lat, e_err ? 1 : 2 + rdly);
            chk($sformatf("rnd%0d_load_data", n), load_data, ld_track);
            if (!e_err) chk($sformatf("rnd%0d_addr", n), o.maddr, ra & 32'hFFFF_FFFC);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
